mul_booth42_iter: RTL and testbench

- Iterative radix-4 Booth multiplier / multiply-accumulator for the integer execute path (MUL, MLA, UMULL, SMULL, UMLAL, SMLAL).
- Each RUN cycle consumes SLICE multiplier bits, producing SLICE/2 Booth partial products.
- A row of 4:2 compressors reduces those partial products into a carry-save sum/carry pair that is held in registers.
- Early termination stops iteration once the remaining multiplier bits carry no information. One final carry-propagate cycle then resolves the result and flags.

---
 rtl/mul_booth42_iter_if.sv | 34 +++
 rtl/mul_booth42_iter.sv | 202 ++++++++++++++++++++
 tb/tb_mul_booth42_iter.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_booth42_iter_if.sv
// Request/response bundle for the iterative Booth multiplier.
// Latency: n/a (wiring only); request fields are sampled on the accepted start edge.
// Backpressure: requester watches busy; a start raised while busy is dropped.
interface mul_booth42_iter_if #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
);
    localparam int CW = $clog2(WIDTH / SLICE + 2);

    logic                 start;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic [2*WIDTH-1:0]   acc_in;
    logic                 sgn;
    logic                 acc_en;
    logic                 long_en;

    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   result;
    logic                 n_flag;
    logic                 z_flag;
    logic [CW-1:0]        cycles;

    modport master (
        output start, a, b, acc_in, sgn, acc_en, long_en,
        input  busy, done, result, n_flag, z_flag, cycles
    );

    modport slave (
        input  start, a, b, acc_in, sgn, acc_en, long_en,
        output busy, done, result, n_flag, z_flag, cycles
    );
endinterface

// File: rtl/mul_booth42_iter.sv
// Iterative radix-4 Booth multiply/accumulate with carry-save state and early termination.
// Latency: done in cycle k+2 after the start edge, k = RUN slices used (1 .. WIDTH/SLICE+1).
// Backpressure: start only honoured in IDLE; requests while busy are ignored, not queued.
module mul_booth42_iter #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic              clk,
    input  logic              nreset,
    mul_booth42_iter_if.slave bus
);
    localparam int PW   = 2 * WIDTH;          // product / carry-save width
    localparam int BW   = WIDTH + SLICE;      // extended multiplier width
    localparam int NPP  = SLICE / 2;          // Booth digits per slice
    localparam int NOPS = NPP + 3;            // sum, carry, partial products, negate correction
    localparam int NPAD = ((NOPS + 3) / 4) * 4;
    localparam int LVLS = $clog2(NPAD) - 1;   // 4:2 levels to get down to two rows
    localparam int CW   = $clog2(WIDTH / SLICE + 2);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_RESOLVE} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   sum_q, sum_d;
    logic [PW-1:0]   carry_q, carry_d;
    logic [PW-1:0]   a_sh_q, a_sh_d;          // extended multiplicand pre-shifted by k*SLICE
    logic [BW-1:0]   b_sh_q, b_sh_d;          // extended multiplier, arithmetically shifted by k*SLICE
    logic            bprev_q, bprev_d;        // multiplier bit k*SLICE-1 (Booth overlap bit)
    logic            long_q, long_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   cycles_q, cycles_d;
    logic [PW-1:0]   result_q, result_d;
    logic            n_q, n_d;
    logic            z_q, z_d;
    logic            done_q, done_d;

    logic [SLICE:0]  win;
    logic [NPP-1:0]  one_w, two_w, neg_w;
    logic [PW-1:0]   mag [NPP];
    logic [PW-1:0]   pp  [NPP];
    logic [PW-1:0]   neg_cnt;
    logic [PW-1:0]   red [NPAD];
    logic [PW-1:0]   nxt [NPAD];
    logic [PW-1:0]   resolved;
    logic            term;

    // 4:2 compressor on whole rows: two cascaded 3:2 stages, top carry drops (mod 2^PW).
    function automatic logic [2*PW-1:0] comp42(input logic [PW-1:0] x0, input logic [PW-1:0] x1,
                                                input logic [PW-1:0] x2, input logic [PW-1:0] x3);
        logic [PW-1:0] t, m, s, c;
        t = x0 ^ x1 ^ x2;
        m = ((x0 & x1) | (x0 & x2) | (x1 & x2)) << 1;
        s = t ^ x3 ^ m;
        c = ((t & x3) | (t & m) | (x3 & m)) << 1;
        return {c, s};
    endfunction

    // Current slice bits plus the overlap bit below them.
    assign win = {b_sh_q[SLICE-1:0], bprev_q};

    // Remaining multiplier bits all equal means every later Booth digit is zero.
    assign term = (&b_sh_q[BW-1:SLICE-1]) | ~(|b_sh_q[BW-1:SLICE-1]);

    assign resolved = sum_q + carry_q;

    // Booth recoding and partial-product selection; negation as ~x with the +1s gathered into one count row.
    always_comb begin
        one_w   = '0;
        two_w   = '0;
        neg_w   = '0;
        neg_cnt = '0;
        for (int i = 0; i < NPP; i++) begin
            one_w[i] = win[2*i+1] ^ win[2*i];
            two_w[i] = (win[2*i+2] & ~win[2*i+1] & ~win[2*i]) |
                       (~win[2*i+2] & win[2*i+1] & win[2*i]);
            neg_w[i] = win[2*i+2] & ~(win[2*i+1] & win[2*i]);
            mag[i]   = one_w[i] ? (a_sh_q << (2*i)) :
                       two_w[i] ? (a_sh_q << (2*i+1)) : '0;
            pp[i]    = neg_w[i] ? ~mag[i] : mag[i];
            neg_cnt  = neg_cnt + PW'(neg_w[i]);
        end
    end

    // Compressor tree folding the partial products into the held sum/carry pair.
    always_comb begin
        for (int i = 0; i < NPAD; i++) begin
            red[i] = '0;
            nxt[i] = '0;
        end
        red[0] = sum_q;
        red[1] = carry_q;
        for (int i = 0; i < NPP; i++) begin
            red[2+i] = pp[i];
        end
        red[NOPS-1] = neg_cnt;
        for (int lvl = 0; lvl < LVLS; lvl++) begin
            for (int i = 0; i < NPAD; i++) begin
                nxt[i] = '0;
            end
            for (int g = 0; g < NPAD; g += 4) begin
                {nxt[g/2+1], nxt[g/2]} = comp42(red[g], red[g+1], red[g+2], red[g+3]);
            end
            for (int i = 0; i < NPAD; i++) begin
                red[i] = nxt[i];
            end
        end
    end

    // Next state and datapath register updates for IDLE -> RUN -> RESOLVE.
    always_comb begin
        state_d  = state_q;
        sum_d    = sum_q;
        carry_d  = carry_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        bprev_d  = bprev_q;
        long_d   = long_q;
        cnt_d    = cnt_q;
        cycles_d = cycles_q;
        result_d = result_q;
        n_d      = n_q;
        z_d      = z_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_RUN;
                    a_sh_d  = bus.sgn ? {{WIDTH{bus.a[WIDTH-1]}}, bus.a} : {{WIDTH{1'b0}}, bus.a};
                    b_sh_d  = bus.sgn ? {{SLICE{bus.b[WIDTH-1]}}, bus.b} : {{SLICE{1'b0}}, bus.b};
                    bprev_d = 1'b0;
                    if (!bus.acc_en)
                        sum_d = '0;
                    else if (bus.long_en)
                        sum_d = bus.acc_in;
                    else
                        sum_d = {{WIDTH{1'b0}}, bus.acc_in[WIDTH-1:0]};
                    carry_d = '0;
                    long_d  = bus.long_en;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                sum_d   = red[0];
                carry_d = red[1];
                a_sh_d  = a_sh_q << SLICE;
                b_sh_d  = {{SLICE{b_sh_q[BW-1]}}, b_sh_q[BW-1:SLICE]};
                bprev_d = b_sh_q[SLICE-1];
                cnt_d   = cnt_q + CW'(1);
                if (term)
                    state_d = S_RESOLVE;
            end
            S_RESOLVE: begin
                result_d = long_q ? resolved : {{WIDTH{1'b0}}, resolved[WIDTH-1:0]};
                n_d      = long_q ? resolved[PW-1] : resolved[WIDTH-1];
                z_d      = long_q ? (resolved == '0) : (resolved[WIDTH-1:0] == '0);
                cycles_d = cnt_q;
                done_d   = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation without a done pulse.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q  <= S_IDLE;
            sum_q    <= '0;
            carry_q  <= '0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            bprev_q  <= 1'b0;
            long_q   <= 1'b0;
            cnt_q    <= '0;
            cycles_q <= '0;
            result_q <= '0;
            n_q      <= 1'b0;
            z_q      <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sum_q    <= sum_d;
            carry_q  <= carry_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            bprev_q  <= bprev_d;
            long_q   <= long_d;
            cnt_q    <= cnt_d;
            cycles_q <= cycles_d;
            result_q <= result_d;
            n_q      <= n_d;
            z_q      <= z_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy   = (state_q != S_IDLE);
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.n_flag = n_q;
    assign bus.z_flag = z_q;
    assign bus.cycles = cycles_q;
endmodule

// File: tb/tb_mul_booth42_iter.sv
// Bench for mul_booth42_iter: directed vector table, random ops against an arithmetic model, corner sequences.
// Latency: expects done in cycle cycles+2 after the start edge.
// Backpressure: checks that a start raised while busy is dropped.
module tb_mul_booth42_iter;
    localparam int W = 32;
    localparam int S = 8;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] acc;
        logic        sgn;
        logic        acc_en;
        logic        long_en;
        logic [63:0] exp_res;
        logic [3:0]  exp_cyc;
        logic        exp_n;
        logic        exp_z;
    } vec_t;

    logic clk = 1'b0;
    logic nreset = 1'b0;
    int   errs = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    mul_booth42_iter_if #(.WIDTH(W), .SLICE(S)) bus ();
    mul_booth42_iter #(.WIDTH(W), .SLICE(S)) dut (.clk(clk), .nreset(nreset), .bus(bus));

    function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic [63:0] acc,
                                input logic sgn, input logic acc_en, input logic long_en,
                                input logic [63:0] r, input int cyc, input logic n, input logic z);
        vec_t v;
        v.a = a; v.b = b; v.acc = acc; v.sgn = sgn; v.acc_en = acc_en; v.long_en = long_en;
        v.exp_res = r; v.exp_cyc = 4'(cyc); v.exp_n = n; v.exp_z = z;
        return v;
    endfunction

    // Plain-arithmetic reference: extend, multiply, add, truncate.
    function automatic logic [63:0] model_res(input vec_t v);
        logic [63:0] ax, bx, p;
        ax = v.sgn ? {{32{v.a[31]}}, v.a} : {32'b0, v.a};
        bx = v.sgn ? {{32{v.b[31]}}, v.b} : {32'b0, v.b};
        p  = ax * bx;
        if (v.acc_en) p = p + (v.long_en ? v.acc : {32'b0, v.acc[31:0]});
        if (!v.long_en) p[63:32] = 32'b0;
        return p;
    endfunction

    // Slices needed: first k whose remaining extended-multiplier bits are all equal.
    function automatic int model_cyc(input vec_t v);
        logic [39:0] bx;
        logic        same;
        bx = v.sgn ? {{8{v.b[31]}}, v.b} : {8'b0, v.b};
        for (int k = 0; k < 5; k++) begin
            same = 1'b1;
            for (int j = (k + 1) * 8 - 1; j < 40; j++)
                if (bx[j] != bx[39]) same = 1'b0;
            if (same) return k + 1;
        end
        return 5;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Present a request, let the next rising edge take it, then scramble the operand inputs.
    task automatic launch(input vec_t v);
        bus.a = v.a; bus.b = v.b; bus.acc_in = v.acc;
        bus.sgn = v.sgn; bus.acc_en = v.acc_en; bus.long_en = v.long_en;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a = $urandom; bus.b = $urandom; bus.acc_in = {$urandom, $urandom};
        bus.sgn = 1'($urandom_range(0, 1));
        bus.acc_en = 1'($urandom_range(0, 1));
        bus.long_en = 1'($urandom_range(0, 1));
    endtask

    // Count cycles after the start edge until done; lat stays 0 if the budget runs out.
    task automatic wait_done(output int lat, output logic busy1, output logic busy_d);
        lat = 0; busy1 = 1'b0; busy_d = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) busy1 = bus.busy;
            if (bus.done) begin
                lat = i;
                busy_d = bus.busy;
                break;
            end
        end
    endtask

    task automatic check_outputs(input string tag, input vec_t v, input int lat);
        chk({tag, "_result"}, bus.result, v.exp_res);
        chk({tag, "_cycles"}, 64'(bus.cycles), 64'(v.exp_cyc));
        chk({tag, "_n"}, 64'(bus.n_flag), 64'(v.exp_n));
        chk({tag, "_z"}, 64'(bus.z_flag), 64'(v.exp_z));
        chk({tag, "_latency"}, 64'(lat), 64'(v.exp_cyc) + 64'd2);
    endtask

    vec_t tbl [10];

    initial begin
        int   lat, dn;
        logic b1, bd;
        logic [63:0] r;
        vec_t v;

        tbl[0] = mk(32'd3, 32'd5, 64'd0, 0, 0, 0, 64'h0000_0000_0000_000F, 1, 0, 0);
        tbl[1] = mk(32'hFFFF_FFFE, 32'hFFFF_FFFD, 64'd0, 1, 0, 1, 64'h0000_0000_0000_0006, 1, 0, 0);
        tbl[2] = mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0, 0, 0, 1, 64'hFFFF_FFFE_0000_0001, 5, 1, 0);
        tbl[3] = mk(32'h8000_0000, 32'h8000_0000, 64'd0, 1, 0, 1, 64'h4000_0000_0000_0000, 4, 0, 0);
        tbl[4] = mk(32'd7, 32'd6, 64'h100, 0, 1, 0, 64'h0000_0000_0000_012A, 1, 0, 0);
        tbl[5] = mk(32'hFFFF_FFFF, 32'd2, 64'd3, 0, 1, 0, 64'h0000_0000_0000_0001, 1, 0, 0);
        tbl[6] = mk(32'd0, 32'd0, 64'd0, 0, 0, 1, 64'h0, 1, 0, 1);
        tbl[7] = mk(32'hFFFF_FFFD, 32'd7, 64'd0, 1, 0, 0, 64'h0000_0000_FFFF_FFEB, 1, 1, 0);
        tbl[8] = mk(32'd2, 32'hFFFF_FFFF, 64'h0000_0001_0000_0000, 1, 1, 1, 64'h0000_0000_FFFF_FFFE, 1, 0, 0);
        tbl[9] = mk(32'h0001_0000, 32'h0001_0000, 64'd0, 0, 0, 0, 64'h0, 3, 0, 1);

        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.acc_in = '0;
        bus.sgn = 1'b0; bus.acc_en = 1'b0; bus.long_en = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_result", bus.result, 64'd0);
        chk("rst_flags", {62'd0, bus.n_flag, bus.z_flag}, 64'd0);
        chk("rst_cycles", 64'(bus.cycles), 64'd0);
        nreset = 1'b1;

        // Directed table
        for (int t = 0; t < 10; t++) begin
            @(posedge clk);
            #1;
            launch(tbl[t]);
            wait_done(lat, b1, bd);
            check_outputs($sformatf("vec%0d", t), tbl[t], lat);
            chk($sformatf("vec%0d_busy_run", t), 64'(b1), 64'd1);
            chk($sformatf("vec%0d_busy_done", t), 64'(bd), 64'd0);
            @(negedge clk);
            chk($sformatf("vec%0d_done_pulse", t), 64'(bus.done), 64'd0);
        end

        // Random operations against the arithmetic model
        for (int t = 0; t < 40; t++) begin
            logic [31:0] m;
            v = mk($urandom, $urandom, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 64'd0, 0, 0, 0);
            m = 32'hFFFF_FFFF >> $urandom_range(0, 31);
            case ($urandom_range(0, 3))
                0: v.b = v.b & m;
                1: v.b = ~(v.b & m);
                2: v.b = v.b | 32'h8000_0000;
                default: ;
            endcase
            v.exp_res = model_res(v);
            v.exp_cyc = 4'(model_cyc(v));
            v.exp_n   = v.long_en ? v.exp_res[63] : v.exp_res[31];
            v.exp_z   = v.long_en ? (v.exp_res == 64'd0) : (v.exp_res[31:0] == 32'd0);
            @(posedge clk);
            #1;
            launch(v);
            wait_done(lat, b1, bd);
            check_outputs($sformatf("rnd%0d", t), v, lat);
        end

        // Second start while busy is dropped
        @(posedge clk);
        #1;
        launch(tbl[2]);
        @(posedge clk);
        #1;
        bus.a = 32'd1; bus.b = 32'd1; bus.sgn = 1'b0; bus.acc_en = 1'b0; bus.long_en = 1'b1;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        dn = 0; r = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.done) begin
                dn++;
                r = bus.result;
            end
        end
        chk("busy_start_done_count", 64'(dn), 64'd1);
        chk("busy_start_result", r, 64'hFFFF_FFFE_0000_0001);

        // Start presented during the done cycle is accepted
        @(posedge clk);
        #1;
        launch(tbl[4]);
        wait_done(lat, b1, bd);
        chk("backtoback_first", bus.result, 64'h12A);
        launch(tbl[0]);
        wait_done(lat, b1, bd);
        chk("backtoback_second", bus.result, 64'hF);
        chk("backtoback_latency", 64'(lat), 64'd3);

        // Reset in the middle of a long run
        @(posedge clk);
        #1;
        launch(tbl[2]);
        @(posedge clk);
        @(posedge clk);
        #2;
        nreset = 1'b0;
        #1;
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_result", bus.result, 64'd0);
        chk("abort_cycles", 64'(bus.cycles), 64'd0);
        chk("abort_done", 64'(bus.done), 64'd0);
        @(posedge clk);
        #1;
        nreset = 1'b1;
        dn = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.done) dn++;
        end
        chk("abort_no_done", 64'(dn), 64'd0);
        chk("abort_idle", 64'(bus.busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errs, checks);
        $fatal(1);
    end
endmodule
